// File: rtl/can_tx_fetch.sv
// Pops one frame word from the TX FIFO, unpacks it and offers it to the CAN transmitter.
// A failed attempt is retried after a fixed backoff until the retry limit is used up.
module can_tx_fetch #(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned RETRY_GAP = 4
) (
    input  logic         i_sys_clk,
    input  logic         i_reset,
    input  logic         i_fifo_empty,
    input  logic [127:0] i_fifo_r_data,
    output logic         o_fifo_r_en,
    input  logic         i_abort,
    output logic         o_tx_valid,
    input  logic         i_tx_ready,
    input  logic         i_tx_done,
    input  logic         i_tx_fail,
    output logic [28:0]  o_tx_id,
    output logic         o_tx_ide,
    output logic         o_tx_rtr,
    output logic [3:0]   o_tx_dlc,
    output logic [63:0]  o_tx_data,
    output logic         o_busy,
    output logic         o_sent,
    output logic         o_drop,
    output logic [3:0]   o_retry_cnt
);

    typedef enum logic [1:0] {StIdle, StReq, StBusy, StBackoff} state_e;

    state_e      state_q, state_d;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] gap_q, gap_d;
    logic        sent_d, drop_d;
    logic        sent_q, drop_q;

    logic [28:0] id_q;
    logic        ide_q, rtr_q;
    logic [3:0]  dlc_q;
    logic [63:0] data_q;
    logic [3:0]  raw_dlc;
    logic        unused_rsvd;

    assign unused_rsvd = ^i_fifo_r_data[92:64];
    assign raw_dlc     = i_fifo_r_data[96:93];

    assign o_fifo_r_en = (state_q == StIdle) && !i_fifo_empty && !i_abort;
    assign o_tx_valid  = (state_q == StReq);
    assign o_busy      = (state_q != StIdle);
    assign o_sent      = sent_q;
    assign o_drop      = drop_q;
    assign o_retry_cnt = retry_q;
    assign o_tx_id     = id_q;
    assign o_tx_ide    = ide_q;
    assign o_tx_rtr    = rtr_q;
    assign o_tx_dlc    = dlc_q;
    assign o_tx_data   = data_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        gap_d   = gap_q;
        sent_d  = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (o_fifo_r_en) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (i_abort) begin
                    state_d = StIdle;
                    drop_d  = 1'b1;
                    retry_d = 4'd0;
                end else if (i_tx_ready) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // done has priority over a coincident fail
                if (i_tx_done) begin
                    state_d = StIdle;
                    sent_d  = 1'b1;
                    retry_d = 4'd0;
                end else if (i_tx_fail) begin
                    if ((retry_q == 4'(MAX_RETRY)) || i_abort) begin
                        state_d = StIdle;
                        drop_d  = 1'b1;
                        retry_d = 4'd0;
                    end else begin
                        state_d = StBackoff;
                        retry_d = retry_q + 4'd1;
                        gap_d   = 16'd0;
                    end
                end
            end
            StBackoff: begin
                if (i_abort) begin
                    state_d = StIdle;
                    drop_d  = 1'b1;
                    retry_d = 4'd0;
                    gap_d   = 16'd0;
                end else if (gap_q == 16'(RETRY_GAP - 1)) begin
                    state_d = StReq;
                    gap_d   = 16'd0;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            retry_q <= 4'd0;
            gap_q   <= 16'd0;
            sent_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            gap_q   <= gap_d;
            sent_q  <= sent_d;
            drop_q  <= drop_d;
        end
    end

    // Frame buffer is loaded on the same edge that pops the FIFO head
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            id_q   <= 29'd0;
            ide_q  <= 1'b0;
            rtr_q  <= 1'b0;
            dlc_q  <= 4'd0;
            data_q <= 64'd0;
        end else if (o_fifo_r_en) begin
            id_q   <= i_fifo_r_data[127:99];
            ide_q  <= i_fifo_r_data[98];
            rtr_q  <= i_fifo_r_data[97];
            dlc_q  <= (raw_dlc > 4'd8) ? 4'd8 : raw_dlc;
            data_q <= i_fifo_r_data[63:0];
        end
    end

endmodule
